pe_share_sched: RTL and testbench

Round-robin scheduler that shares one bit-serial signed multiplier PE among NUM_REQ requesters. It latches the winning requester's operands and drives the PE valid/load window for exactly 2*BITWIDTH cycles. It then waits for the PE's done strobe, with a timeout, and returns the product to that requester with a one-cycle ack. It sits between the requesting datapath units and the PE plus its pacing counter.

---
 rtl/pe_share_sched_if.sv | 33 +++
 rtl/pe_share_sched.sv | 106 ++++++++++
 tb/tb_pe_share_sched.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pe_share_sched_if.sv
// Requester and PE bus bundle for the shared bit-serial multiplier scheduler.
// master = scheduler view, slave = requester/PE environment view.
interface pe_share_sched_if #(
  parameter int BITWIDTH = 8,
  parameter int NUM_REQ  = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*BITWIDTH-1:0] req_a;
  logic [NUM_REQ*BITWIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]          ack;
  logic [2*BITWIDTH-1:0]       rsp_data;
  logic                        rsp_err;
  logic                        pe_valid;
  logic                        pe_load;
  logic [BITWIDTH-1:0]         pe_a;
  logic [BITWIDTH-1:0]         pe_b;
  logic [2*BITWIDTH-1:0]       pe_result;
  logic                        pe_done;
  logic                        busy;
  logic [GW-1:0]               gnt_id;

  modport master (
    input  req, req_a, req_b, pe_result, pe_done,
    output ack, rsp_data, rsp_err, pe_valid, pe_load, pe_a, pe_b, busy, gnt_id
  );

  modport slave (
    output req, req_a, req_b, pe_result, pe_done,
    input  ack, rsp_data, rsp_err, pe_valid, pe_load, pe_a, pe_b, busy, gnt_id
  );
endinterface

// File: rtl/pe_share_sched.sv
// Round-robin share of one bit-serial PE; ack 2*BITWIDTH+1 .. 2*BITWIDTH+TIMEOUT cycles after grant.
// No backpressure: a requester holds req/operands until its one-cycle ack, then drops req.
module pe_share_sched #(
  parameter int BITWIDTH = 8,
  parameter int NUM_REQ  = 4,
  parameter int TIMEOUT  = 16
) (
  input logic              fast_clk,
  input logic              rst,
  pe_share_sched_if.master bus
);
  localparam int GW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WIN  = 2 * BITWIDTH;
  localparam int CMAX = (WIN > TIMEOUT) ? WIN : TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]    state;
  logic [GW-1:0] rr_ptr;
  logic [CW-1:0] cnt;
  logic          found;
  logic [GW-1:0] win;

  // First set request scanning upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        win   = GW'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge fast_clk) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      cnt          <= '0;
      bus.ack      <= '0;
      bus.rsp_data <= '0;
      bus.rsp_err  <= 1'b0;
      bus.pe_valid <= 1'b0;
      bus.pe_load  <= 1'b0;
      bus.pe_a     <= '0;
      bus.pe_b     <= '0;
      bus.busy     <= 1'b0;
      bus.gnt_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            bus.pe_a     <= bus.req_a[int'(win)*BITWIDTH +: BITWIDTH];
            bus.pe_b     <= bus.req_b[int'(win)*BITWIDTH +: BITWIDTH];
            bus.gnt_id   <= win;
            bus.pe_valid <= 1'b1;
            bus.pe_load  <= 1'b1;
            bus.busy     <= 1'b1;
            cnt          <= '0;
            state        <= RUN;
          end
        end
        RUN: begin
          bus.pe_load <= 1'b0;
          if (cnt == CW'(WIN - 1)) begin
            cnt          <= '0;
            bus.pe_valid <= 1'b0;
            state        <= WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          // A done strobe on the final timeout cycle still yields a normal response.
          if (bus.pe_done) begin
            bus.rsp_data <= bus.pe_result;
            bus.rsp_err  <= 1'b0;
            bus.ack      <= NUM_REQ'(1) << bus.gnt_id;
            state        <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b1;
            bus.ack      <= NUM_REQ'(1) << bus.gnt_id;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          bus.ack      <= '0;
          bus.rsp_data <= '0;
          bus.rsp_err  <= 1'b0;
          bus.busy     <= 1'b0;
          rr_ptr       <= (bus.gnt_id == GW'(NUM_REQ - 1)) ? '0 : bus.gnt_id + 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pe_share_sched.sv
// Directed bench for pe_share_sched: vector table of single operations plus fairness and reset sequences.
module tb_pe_share_sched;
  localparam int BW = 8;
  localparam int NR = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pe_share_sched_if #(.BITWIDTH(BW), .NUM_REQ(NR)) bus ();

  pe_share_sched #(.BITWIDTH(BW), .NUM_REQ(NR), .TIMEOUT(16)) dut (
    .fast_clk (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    int          win;
    logic [7:0]  a;
    logic [7:0]  b;
    int          done_at;   // WAIT cycle index carrying pe_done, -1 = never
    int          pulse_k;   // cycle index of a stray pe_done during RUN, -1 = none
    int          chg_k;     // cycle index at which req_a is overwritten with -1, -1 = none
    logic [15:0] res;
    int          lat;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int  t;
    int  k;
    int  vcnt;
    int  lcnt;
    bit  opok;
    for (int i = 0; i < NR; i++) begin
      if (v.mask[i]) begin
        bus.req_a[i*BW +: BW] = v.a;
        bus.req_b[i*BW +: BW] = v.b;
      end
    end
    bus.pe_result = v.res;
    bus.req = bus.req | v.mask;
    t = 0;
    while (!bus.pe_load && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk("grant_seen", 32'(bus.pe_load), 32'd1);
    chk("gnt_id", 32'(bus.gnt_id), 32'(v.win));
    k = 0; vcnt = 0; lcnt = 0; opok = 1'b1;
    while (bus.ack == '0 && k < 80) begin
      if (bus.pe_valid) begin
        vcnt++;
        if (bus.pe_a !== v.a || bus.pe_b !== v.b) opok = 1'b0;
      end
      if (bus.pe_load) lcnt++;
      if (k == v.chg_k) bus.req_a[v.win*BW +: BW] = 8'hFF;
      bus.pe_done = (v.done_at >= 0 && k == 16 + v.done_at) || (k == v.pulse_k);
      @(posedge clk); #1;
      k++;
    end
    bus.pe_done = 1'b0;
    chk("ack_latency", 32'(k), 32'(v.lat));
    chk("ack_onehot", 32'(bus.ack), 32'(4'b0001 << v.win));
    chk("rsp_data", 32'(bus.rsp_data), 32'(v.exp_data));
    chk("rsp_err", 32'(bus.rsp_err), 32'(v.exp_err));
    chk("valid_cycles", 32'(vcnt), 32'd16);
    chk("load_cycles", 32'(lcnt), 32'd1);
    chk("operands_held", 32'(opok), 32'd1);
    bus.req = bus.req & ~v.mask;
    @(posedge clk); #1;
    chk("ack_clear", 32'(bus.ack), 32'd0);
    chk("rsp_clear", 32'({bus.rsp_err, bus.rsp_data}), 32'd0);
    chk("busy_low", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t;
    int k;
    int g;
    vec_t rv;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    bus.pe_result = '0; bus.pe_done = 1'b0;

    vecs[0] = '{mask:4'b0100, win:2, a:8'hFD, b:8'h05, done_at:0, pulse_k:-1, chg_k:-1,
                res:16'hFFF1, lat:17, exp_data:16'hFFF1, exp_err:1'b0};
    vecs[1] = '{mask:4'b0010, win:1, a:8'h11, b:8'h22, done_at:-1, pulse_k:-1, chg_k:-1,
                res:16'h1234, lat:32, exp_data:16'h0000, exp_err:1'b1};
    vecs[2] = '{mask:4'b0101, win:2, a:8'h80, b:8'h80, done_at:2, pulse_k:3, chg_k:-1,
                res:16'h4000, lat:19, exp_data:16'h4000, exp_err:1'b0};
    vecs[3] = '{mask:4'b0001, win:0, a:8'h07, b:8'h03, done_at:1, pulse_k:-1, chg_k:8,
                res:16'h0015, lat:18, exp_data:16'h0015, exp_err:1'b0};
    vecs[4] = '{mask:4'b1000, win:3, a:8'h7F, b:8'hFF, done_at:0, pulse_k:-1, chg_k:-1,
                res:16'hFF81, lat:17, exp_data:16'hFF81, exp_err:1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs", 32'({bus.ack, bus.rsp_err, bus.pe_valid, bus.pe_load, bus.busy}), 32'd0);
    chk("rst_data", 32'({bus.pe_a, bus.pe_b, bus.gnt_id}), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Fairness: all requesters held, each re-raised one cycle after its ack.
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_a = '0; bus.req_b = '0; bus.pe_result = 16'h0001;
    bus.req = 4'b1111;
    t = 0;
    for (int op = 0; op < 6; op++) begin
      while (!bus.pe_load && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      if (op > 0) chk("rr_gap", 32'(t), 32'd2);
      chk("rr_order", 32'(bus.gnt_id), 32'(op % NR));
      k = 0;
      while (bus.ack == '0 && k < 60) begin
        bus.pe_done = (k == 16);
        @(posedge clk); #1;
        k++;
      end
      bus.pe_done = 1'b0;
      g = op % NR;
      chk("rr_ack", 32'(bus.ack), 32'(4'b0001 << g));
      bus.req[g] = 1'b0;
      @(posedge clk); #1;
      t = 1;
      bus.req[g] = 1'b1;
    end
    bus.req = '0;
    repeat (40) begin
      @(posedge clk); #1;
      bus.pe_done = bus.busy && !bus.pe_valid;
      if (!bus.busy) break;
    end
    bus.pe_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a RUN window, request kept high across it.
    bus.req_a[3*BW +: BW] = 8'h02;
    bus.req_b[3*BW +: BW] = 8'hFE;
    bus.req = 4'b1000;
    t = 0;
    while (!bus.pe_load && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.pe_valid), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_gnt", 32'(bus.gnt_id), 32'd0);
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    rst = 1'b1;
    rv = '{mask:4'b1000, win:3, a:8'h02, b:8'hFE, done_at:0, pulse_k:-1, chg_k:-1,
           res:16'hFFFC, lat:17, exp_data:16'hFFFC, exp_err:1'b0};
    run_op(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
